// File: rtl/counter_snapshot.sv
// Extends a small free-running upstream counter with a wrap count, flags sequence
// errors, and hands out coherent {ext, cnt} snapshots over a valid/ready port.
module counter_snapshot #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned EXT_W = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   cnt_clr,
  input  logic                   snap_req,
  input  logic                   snap_ready,
  output logic                   snap_valid,
  output logic [EXT_W+CNT_W-1:0] snap_data,
  output logic                   wrap_pulse,
  output logic                   overflow,
  output logic                   seq_err
);

  localparam int unsigned SNAP_W = EXT_W + CNT_W;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   prev;
  logic               prev_vld;
  logic [EXT_W-1:0]   ext;
  logic               pending;

  logic               wrap;
  logic               seq_bad;
  logic               handshake;
  logic [EXT_W-1:0]   ext_next;
  logic [SNAP_W-1:0]  cap;

  // Wrap/sequence detection and the value a capture in this cycle would take.
  always_comb begin
    wrap      = prev_vld && !cnt_clr && (prev == {CNT_W{1'b1}}) && (cnt_in == '0);
    seq_bad   = prev_vld && !cnt_clr && (cnt_in != CNT_W'(prev + CNT_W'(1)));
    ext_next  = ext;
    if (cnt_clr) begin
      ext_next = '0;
    end else if (wrap) begin
      ext_next = ext + EXT_W'(1);
    end
    cap       = {ext_next, cnt_in};
    handshake = snap_valid && snap_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= '0;
      prev_vld   <= 1'b0;
      ext        <= '0;
      pending    <= 1'b0;
      snap_valid <= 1'b0;
      snap_data  <= '0;
      wrap_pulse <= 1'b0;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      prev       <= cnt_in;
      prev_vld   <= !cnt_clr;
      ext        <= ext_next;
      wrap_pulse <= wrap;

      if (cnt_clr) begin
        overflow <= 1'b0;
      end else if (wrap && (ext == {EXT_W{1'b1}})) begin
        overflow <= 1'b1;
      end

      if (seq_bad) begin
        seq_err <= 1'b1;
      end

      // Snapshot FSM: a request seen while holding is merged into one pending slot.
      case (state)
        IDLE: begin
          if (snap_req) begin
            snap_data  <= cap;
            snap_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            pending <= 1'b0;
            if (pending || snap_req) begin
              snap_data <= cap;
            end else begin
              snap_valid <= 1'b0;
              state      <= IDLE;
            end
          end else if (snap_req) begin
            pending <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_snapshot.sv
// Directed plus randomized bench for counter_snapshot; a wide (EXT_W=12) and a
// narrow (EXT_W=2) instance share stimulus and are compared to a wrap-count model.
module tb_counter_snapshot;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cnt_in;
  logic        cnt_clr;
  logic        snap_req;
  logic        snap_ready;

  logic        snap_valid, wrap_pulse, overflow, seq_err;
  logic [15:0] snap_data;
  logic        snap_valid2, wrap_pulse2, overflow2, seq_err2;
  logic [5:0]  snap_data2;

  int checks = 0;
  int errors = 0;

  // Reference model state: wraps counted since the last clear, as a plain integer.
  int m_prev;
  bit m_prev_vld;
  int m_wraps;
  bit m_seq;
  bit m_wp;
  bit m_v;
  bit m_pend;
  int m_d12;
  int m_d2;
  int cur;

  always #5 clk = ~clk;

  counter_snapshot #(.CNT_W(4), .EXT_W(12)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_clr(cnt_clr),
    .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(snap_valid),
    .snap_data(snap_data), .wrap_pulse(wrap_pulse), .overflow(overflow),
    .seq_err(seq_err)
  );

  counter_snapshot #(.CNT_W(4), .EXT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_clr(cnt_clr),
    .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(snap_valid2),
    .snap_data(snap_data2), .wrap_pulse(wrap_pulse2), .overflow(overflow2),
    .seq_err(seq_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input int c, input bit clr, input bit req, input bit rdy, input bit rst_n);
    bit w;
    int cap12, cap2;
    reset      = rst_n;
    cnt_in     = 4'(c);
    cnt_clr    = clr;
    snap_req   = req;
    snap_ready = rdy;
    if (!rst_n) begin
      m_prev = 0; m_prev_vld = 0; m_wraps = 0; m_seq = 0; m_wp = 0;
      m_v = 0; m_pend = 0; m_d12 = 0; m_d2 = 0;
    end else begin
      w = m_prev_vld && !clr && (m_prev == 15) && (c == 0);
      if (m_prev_vld && !clr && (c != (m_prev + 1) % 16)) m_seq = 1;
      if (clr) m_wraps = 0;
      else if (w) m_wraps++;
      m_wp  = w;
      cap12 = ((m_wraps % 4096) * 16) + c;
      cap2  = ((m_wraps % 4) * 16) + c;
      if (!m_v) begin
        if (req) begin m_v = 1; m_d12 = cap12; m_d2 = cap2; end
      end else if (rdy) begin
        if (m_pend || req) begin m_d12 = cap12; m_d2 = cap2; end
        else m_v = 0;
        m_pend = 0;
      end else if (req) begin
        m_pend = 1;
      end
      m_prev     = c;
      m_prev_vld = !clr;
    end
    @(posedge clk);
    #1;
    chk("valid",    32'(snap_valid),  32'(m_v));
    chk("data",     32'(snap_data),   32'(m_d12));
    chk("wrap",     32'(wrap_pulse),  32'(m_wp));
    chk("overflow", 32'(overflow),    32'(m_wraps >= 4096));
    chk("seq_err",  32'(seq_err),     32'(m_seq));
    chk("valid2",   32'(snap_valid2), 32'(m_v));
    chk("data2",    32'(snap_data2),  32'(m_d2));
    chk("wrap2",    32'(wrap_pulse2), 32'(m_wp));
    chk("overflow2",32'(overflow2),   32'(m_wraps >= 4));
    chk("seq_err2", 32'(seq_err2),    32'(m_seq));
  endtask

  task automatic adv(input bit req, input bit rdy);
    cur = (cur + 1) % 16;
    step(cur, 1'b0, req, rdy, 1'b1);
  endtask

  initial begin
    int r;
    cur = 0;
    reset = 1'b0; cnt_in = '0; cnt_clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;

    // Reset held with requests and a toggling counter.
    step(3, 0, 1, 0, 0);
    step(12, 0, 1, 0, 0);
    chk("rst_valid", 32'(snap_valid), 32'd0);
    chk("rst_data", 32'(snap_data), 32'd0);

    // First wrap after reset.
    for (int i = 0; i < 16; i++) step(i, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    cur = 0;
    chk("wrap_first", 32'(wrap_pulse), 32'd1);
    adv(0, 1);
    chk("wrap_one_cycle", 32'(wrap_pulse), 32'd0);
    adv(1, 1);
    chk("ext_one_snap", 32'(snap_data), 32'h012);
    chk("seq_clean", 32'(seq_err), 32'd0);

    // Basic snapshot after three wraps.
    while (!(m_wraps == 3 && cur == 4)) adv(0, 1);
    adv(1, 1);
    chk("snap_basic_valid", 32'(snap_valid), 32'd1);
    chk("snap_basic_data", 32'(snap_data), 32'h035);
    adv(0, 1);
    chk("snap_basic_drop", 32'(snap_valid), 32'd0);

    // Clear for two cycles, then backpressure with a merged pending request.
    step(7, 1, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    cur = 0;
    chk("clr_no_wrap", 32'(wrap_pulse), 32'd0);
    adv(0, 0);
    adv(1, 0);
    chk("bp_data", 32'(snap_data), 32'h002);
    adv(0, 0);
    adv(1, 0);
    for (int i = 0; i < 4; i++) begin
      adv(i == 1, 0);
      chk("bp_hold", 32'(snap_data), 32'h002);
    end
    adv(0, 1);
    chk("bp_recap_valid", 32'(snap_valid), 32'd1);
    chk("bp_recap_data", 32'(snap_data), 32'h009);
    adv(0, 1);
    chk("bp_drop", 32'(snap_valid), 32'd0);

    // Capture coincident with the 8th wrap.
    while (!(m_wraps == 7 && cur == 15)) adv(0, 1);
    adv(1, 1);
    chk("wrap_capture", 32'(snap_data), 32'h080);
    chk("ovf2_set", 32'(overflow2), 32'd1);
    chk("ovf12_clear", 32'(overflow), 32'd0);
    adv(0, 1);
    step(cur, 1, 0, 1, 1);
    chk("ovf2_cleared", 32'(overflow2), 32'd0);

    // Sequence error sticks through counting and clears only on reset.
    step(0, 0, 0, 1, 1);
    cur = 0;
    for (int i = 0; i < 4; i++) adv(0, 1);
    chk("seq_before_jump", 32'(seq_err), 32'd0);
    step(9, 0, 0, 1, 1);
    cur = 9;
    chk("seq_jump", 32'(seq_err), 32'd1);
    step(0, 1, 0, 1, 1);
    cur = 0;
    adv(0, 1);
    chk("seq_sticky", 32'(seq_err), 32'd1);
    step(cur, 0, 0, 1, 0);
    chk("seq_reset", 32'(seq_err), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(99));
      if (r < 2) begin
        step(cur, 0, $urandom_range(1), $urandom_range(1), 0);
      end else if (r < 6) begin
        cur = int'($urandom_range(15));
        step(cur, 1, ($urandom_range(9) < 3), $urandom_range(1), 1);
      end else if (r < 9) begin
        cur = int'($urandom_range(15));
        step(cur, 0, ($urandom_range(9) < 3), $urandom_range(1), 1);
      end else begin
        adv(($urandom_range(9) < 3), $urandom_range(1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_snapshot.md
Name: counter_snapshot

Overview:
- Downstream consumer of the 4-bit free-running up counter.
- Detects counter wrap-around (15->0) and extends the count into a wider value.
- Flags sequence errors (missed or extra increments).
- On request, captures a coherent {extension, count} snapshot and presents it on a valid/ready output handshake.

Parameters:
CNT_W, 4, width of incoming counter value
EXT_W, 12, width of wrap-extension counter (snapshot width = EXT_W+CNT_W)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
cnt_in  input  CNT_W  current value of upstream counter, sampled every clk
cnt_clr  input  1  high in cycles where the upstream counter is held in or leaving reset; marks cnt_in as not a normal increment
snap_req  input  1  single-cycle or level request to capture a snapshot
snap_ready  input  1  downstream accepts snapshot
snap_valid  output  1  snapshot data valid
snap_data  output  EXT_W+CNT_W  {ext, cnt} captured value
wrap_pulse  output  1  one-cycle pulse, registered, on detected wrap
overflow  output  1  sticky: extension counter wrapped
seq_err  output  1  sticky: cnt_in was not prev+1 while cnt_clr low

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0; prev=0; prev_vld=0; ext=0; pending=0; state=IDLE. Reset mid-handshake drops the snapshot and any pending request.
- Every cycle: prev<=cnt_in; prev_vld<=1. When cnt_clr=1, prev_vld<=0.
- Wrap detect (wrap): prev_vld && !cnt_clr && prev=={CNT_W{1}} && cnt_in==0.
- wrap_pulse registered: high the cycle after wrap, low otherwise.
- ext_next:
  - cnt_clr -> 0
  - else wrap -> ext+1, modulo 2^EXT_W
  - else ext
  - ext<=ext_next.
- overflow: set when wrap && ext=={EXT_W{1}} (ext goes to 0). Cleared only by reset or cnt_clr.
- seq_err:
  - set when prev_vld && !cnt_clr && cnt_in != (prev+1) mod 2^CNT_W.
  - Cleared only by reset.
  - First sample after reset or cnt_clr is never checked.
- Capture value: {ext_next, cnt_in} of the capture cycle. A wrap or cnt_clr in that same cycle is therefore reflected.
- FSM states: IDLE, HOLD.
  - IDLE: snap_req=1 -> capture, snap_valid<=1, go HOLD. Latency 1 clk from req to valid.
  - HOLD, with handshake = snap_valid && snap_ready:
    - snap_data and snap_valid stay stable while !snap_ready.
    - snap_req without handshake -> pending<=1. Further requests merge; pending is one deep.
    - handshake && (pending || snap_req) -> recapture this cycle, stay HOLD, snap_valid stays 1, pending<=0. Back-to-back throughput is 1 per clk.
    - handshake && !pending && !snap_req -> snap_valid<=0, go IDLE.
- snap_valid never depends combinationally on snap_ready. All outputs are registered.
- cnt_clr does not affect the FSM. A held snapshot remains valid and unchanged.

Test Plan:
- Reset: reset=0 for 2 clk with snap_req=1 and cnt_in toggling -> all outputs 0. Release, feed 0,1,2..15,0 with cnt_clr=0 -> wrap_pulse high for exactly 1 clk, the cycle after cnt_in=0. Internal ext=1 (check via snapshot) and seq_err=0.
- Snapshot basic: after 3 wraps, snap_req=1 with cnt_in=5, snap_ready=1 -> next clk snap_valid=1, snap_data=0x035 (EXT_W=12). snap_valid low the following clk.
- Backpressure/pending: snap_ready=0, request at cnt_in=2 (ext=0). Further requests 2 clk later. Raise snap_ready 5 clk later -> snap_data holds 0x002 throughout. Handshake cycle recaptures the current value. snap_valid stays 1. The second handshake then drops snap_valid.
- Coincident wrap+capture: snap_req=1 in the cycle cnt_in 15->0 with ext=7 -> snap_data=0x080.
- cnt_clr/seq_err: cnt_clr=1 for 2 clk, then counting resumes from 0 -> ext=0, no seq_err, no wrap_pulse. Later inject jump 4->9 with cnt_clr=0 -> seq_err=1 next clk and stays 1 until reset.
- Overflow: set EXT_W=2 in bench, run 4 full wraps -> overflow=1 after the 4th wrap, ext back to 0. cnt_clr=1 -> overflow=0.
